// File: rtl/window_buffer_kxk.sv
// K x K sliding-window generator over a raster pixel stream.
// Optional macro WINBUF_OUT_REG_EN adds one output register stage.
module window_buffer_kxk #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int K      = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic                      in_sof,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      win_valid,
  output logic [K*K*DATA_W-1:0]     win_data,
  output logic [$clog2(IMG_H)-1:0]  win_row,
  output logic [$clog2(IMG_W)-1:0]  win_col,
  output logic                      frame_done
);

  localparam int L   = (K-1)*IMG_W + K;
  localparam int RBW = $clog2(IMG_H);
  localparam int CBW = $clog2(IMG_W);

  logic [DATA_W-1:0]     sh_q [L];
  logic [K*K*DATA_W-1:0] taps;

  logic [CBW-1:0] col_q, col_d, cur_col;
  logic [RBW-1:0] row_q, row_d, cur_row;
  logic           qual, last;

  logic           v1_q, done1_q;
  logic [RBW-1:0] row1_q;
  logic [CBW-1:0] col1_q;

  // Coordinate of the pixel on the input this cycle and its successor.
  always_comb begin
    cur_col = in_sof ? '0 : col_q;
    cur_row = in_sof ? '0 : row_q;
    col_d   = cur_col + 1'b1;
    row_d   = cur_row;
    if (cur_col == CBW'(IMG_W-1)) begin
      col_d = '0;
      if (cur_row == RBW'(IMG_H-1))
        row_d = '0;
      else
        row_d = cur_row + 1'b1;
    end
    qual = (cur_row >= RBW'(K-1)) && (cur_col >= CBW'(K-1));
    last = (cur_row == RBW'(IMG_H-1)) && (cur_col == CBW'(IMG_W-1));
  end

  // Shift line: (K-1) full rows plus K pixels, advancing on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < L; n++)
        sh_q[n] <= '0;
    end else if (in_valid) begin
      sh_q[0] <= in_data;
      for (int n = 1; n < L; n++)
        sh_q[n] <= sh_q[n-1];
    end
  end

  // Window taps: (K-1,K-1) is the newest entry, (0,0) the oldest.
  for (genvar i = 0; i < K; i++) begin : g_row
    for (genvar j = 0; j < K; j++) begin : g_col
      assign taps[(i*K+j)*DATA_W +: DATA_W] =
        sh_q[(K-1-i)*IMG_W + (K-1-j)];
    end
  end

  // Position counters and the first-stage window qualifiers.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      v1_q    <= 1'b0;
      done1_q <= 1'b0;
      row1_q  <= '0;
      col1_q  <= '0;
    end else if (in_valid) begin
      col_q   <= col_d;
      row_q   <= row_d;
      v1_q    <= qual;
      done1_q <= last;
      row1_q  <= cur_row;
      col1_q  <= cur_col;
    end else begin
      v1_q    <= 1'b0;
      done1_q <= 1'b0;
    end
  end

`ifdef WINBUF_OUT_REG_EN
  logic                  win_valid_q, frame_done_q;
  logic [K*K*DATA_W-1:0] win_data_q;
  logic [RBW-1:0]        win_row_q;
  logic [CBW-1:0]        win_col_q;

  // Extra output stage; window data loads only with a valid window.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_data_q   <= '0;
      win_row_q    <= '0;
      win_col_q    <= '0;
    end else begin
      win_valid_q  <= v1_q;
      frame_done_q <= done1_q;
      win_row_q    <= row1_q;
      win_col_q    <= col1_q;
      if (v1_q)
        win_data_q <= taps;
    end
  end

  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;
  assign win_data   = win_data_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;
`else
  assign win_valid  = v1_q;
  assign frame_done = done1_q;
  assign win_data   = taps;
  assign win_row    = row1_q;
  assign win_col    = col1_q;
`endif

endmodule

// File: tb/tb_window_buffer_kxk.sv
// Bench for window_buffer_kxk: default 32x32 K=5 instance checked
// against an image-array model, plus a small K=3 6x6 instance.
module tb_window_buffer_kxk;

`ifdef WINBUF_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         a_valid, a_sof;
  logic [7:0]   a_data;
  logic         a_wv, a_fd;
  logic [199:0] a_wd;
  logic [4:0]   a_wr, a_wc;

  logic         b_valid, b_sof;
  logic [7:0]   b_data;
  logic         b_wv, b_fd;
  logic [71:0]  b_wd;
  logic [2:0]   b_wr, b_wc;

  window_buffer_kxk u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_valid), .in_sof(a_sof), .in_data(a_data),
    .win_valid(a_wv), .win_data(a_wd),
    .win_row(a_wr), .win_col(a_wc), .frame_done(a_fd)
  );

  window_buffer_kxk #(.DATA_W(8), .IMG_W(6), .IMG_H(6), .K(3)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_valid), .in_sof(b_sof), .in_data(b_data),
    .win_valid(b_wv), .win_data(b_wd),
    .win_row(b_wr), .win_col(b_wc), .frame_done(b_fd)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [199:0] got,
                       input logic [199:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic         valid;
    logic         done;
    logic [4:0]   row;
    logic [4:0]   col;
    logic         known;
    logic [199:0] data;
  } mst_t;

  logic [7:0] img [32][32];
  int   mr, mc;
  mst_t m_st, m_prev;

  // Image-level model: windows are read straight out of the 2-D image.
  task automatic model(input logic v, input logic sof,
                       input logic [7:0] d, input logic r);
    int pr, pc;
    if (r) begin
      mr = 0; mc = 0;
      m_st = '0;
      m_st.known = 1'b1;
      m_prev = m_st;
    end else begin
      m_prev = m_st;
      m_st.valid = 1'b0;
      m_st.done  = 1'b0;
      if (v) begin
        if (sof) begin mr = 0; mc = 0; end
        pr = mr; pc = mc;
        img[pr][pc] = d;
        m_st.row   = 5'(pr);
        m_st.col   = 5'(pc);
        m_st.valid = (pr >= 4) && (pc >= 4);
        m_st.done  = (pr == 31) && (pc == 31);
        m_st.known = m_st.valid;
        if (m_st.valid)
          for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
              m_st.data[(i*5+j)*8 +: 8] = img[pr-4+i][pc-4+j];
        mc++;
        if (mc == 32) begin
          mc = 0; mr++;
          if (mr == 32) mr = 0;
        end
      end
    end
  endtask

  int wins, dones, npix, first_win;
  logic [199:0] fw_data;
  logic [4:0]   fw_row, fw_col;

  task automatic clr();
    wins = 0; dones = 0; npix = 0; first_win = -1;
  endtask

  // One clock of instance A: drive at negedge, check at next negedge.
  task automatic step(input logic v, input logic sof,
                      input logic [7:0] d, input logic r);
    mst_t e;
    a_valid = v; a_sof = sof; a_data = d; rst = r;
    model(v, sof, d, r);
    @(posedge clk);
    @(negedge clk);
    e = (LAT == 2) ? m_prev : m_st;
    check("win_valid", 200'(a_wv), 200'(e.valid));
    check("frame_done", 200'(a_fd), 200'(e.done));
    check("win_row", 200'(a_wr), 200'(e.row));
    check("win_col", 200'(a_wc), 200'(e.col));
    if (e.known)
      check("win_data", a_wd, e.data);
    if (a_wv) begin
      if (first_win < 0) begin
        first_win = npix;
        fw_data = a_wd; fw_row = a_wr; fw_col = a_wc;
      end
      wins++;
    end
    if (a_fd) dones++;
    if (v && !r) npix++;
  endtask

  function automatic logic [7:0] rast(input int p);
    int r, c;
    r = p / 32;
    c = p % 32;
    return 8'((r*32 + c) & 8'hFF);
  endfunction

  int   bw;
  logic b22;

  initial begin
    rst = 1'b1;
    a_valid = 0; a_sof = 0; a_data = 0;
    b_valid = 0; b_sof = 0; b_data = 0;
    mr = 0; mc = 0; m_st = '0; m_prev = '0;
    clr();
    @(negedge clk);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // full frame, back-to-back
    clr();
    for (int p = 0; p < 1024; p++)
      step(1, p == 0, rast(p), 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("t1_wins", 200'(wins), 200'(784));
    check("t1_dones", 200'(dones), 200'(1));
    check("t1_first", 200'(first_win), 200'(132 + LAT - 1));
    check("t1_fw_row", 200'(fw_row), 200'(4));
    check("t1_fw_col", 200'(fw_col), 200'(4));
    check("t1_e00", 200'(fw_data[7:0]), 200'(8'h00));
    check("t1_e44", 200'(fw_data[199:192]), 200'(8'h84));

    // same stream with a gap after every pixel
    clr();
    for (int p = 0; p < 1024; p++) begin
      step(1, 1'b0, rast(p), 0);
      step(0, 1'($urandom), 8'($urandom), 0);
    end
    step(0, 0, 0, 0);
    check("t2_wins", 200'(wins), 200'(784));
    check("t2_dones", 200'(dones), 200'(1));

    // start-of-frame on the 100th pixel
    for (int p = 0; p < 99; p++)
      step(1, 0, rast(p), 0);
    clr();
    for (int p = 0; p < 300; p++)
      step(1, p == 0, 8'($urandom), 0);
    step(0, 0, 0, 0);
    check("t3_first", 200'(first_win), 200'(132 + LAT - 1));
    check("t3_wins", 200'(wins), 200'(148));

    // reset after pixel (10,7), with a colliding pixel
    step(0, 0, 0, 1);
    for (int p = 0; p < 328; p++)
      step(1, 0, rast(p), 0);
    step(1, 0, 8'hAA, 1);
    check("t4_rst_data", a_wd, 200'(0));
    clr();
    for (int p = 0; p < 1024; p++)
      step(1, 0, rast(p), 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("t4_wins", 200'(wins), 200'(784));
    check("t4_dones", 200'(dones), 200'(1));

    // random data, gaps and stray start-of-frame pulses
    for (int n = 0; n < 3000; n++)
      step(($urandom % 10) < 7, ($urandom % 300) == 0,
           8'($urandom), 0);

    // K=3, 6x6 instance
    bw = 0; b22 = 1'b0;
    for (int p = 0; p < 40; p++) begin
      b_valid = (p < 36);
      b_sof   = (p == 0);
      b_data  = 8'(p);
      @(posedge clk);
      @(negedge clk);
      if (b_wv) begin
        bw++;
        if (b_wr == 3'd2 && b_wc == 3'd2) begin
          b22 = 1'b1;
          check("k3_win22", 200'(b_wd), 200'(72'h0e0d0c080706020100));
        end
      end
    end
    b_valid = 1'b0;
    check("k3_wins", 200'(bw), 200'(16));
    check("k3_seen22", 200'(b22), 200'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
